// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock core: BCD digit type, time
// record, seven-segment codes and the hour-range limits used by load checks.
package clock_pkg;
  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hh_hi;
    bcd_t hh_lo;
    bcd_t mm_hi;
    bcd_t mm_lo;
    bcd_t ss_hi;
    bcd_t ss_lo;
    logic pm;
  } clock_time_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam bcd_t       DIGIT_MAX  = 4'd9;
  localparam bcd_t       TENS_MAX   = 4'd5;
  localparam logic [7:0] HOUR12_MIN = 8'd1;
  localparam logic [7:0] HOUR12_MAX = 8'd12;
  localparam logic [7:0] HOUR24_MAX = 8'd23;

  function automatic logic [7:0] bcd2_to_bin(input bcd_t hi, input bcd_t lo);
    return ({4'd0, hi} * 8'd10) + {4'd0, lo};
  endfunction
endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes go dark.
module bcd_to_7seg
  import clock_pkg::*;
(
  input  bcd_t       digit_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/alarm_clock_core.sv
// Alarm clock core: BCD HH:MM:SS timekeeping from a clock prescaler, checked
// time/alarm loading, and an alarm output that clears on request or timeout.
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 2,
  parameter bit          MODE_24H      = 1'b0,
  parameter int unsigned ALARM_TIMEOUT = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] Lhourhigh,
  input  logic [3:0] Lhourlow,
  input  logic [3:0] Lminhigh,
  input  logic [3:0] Lminlow,
  input  logic       Lpm,
  input  logic       loadOrNah,
  input  logic       alarm_set_i,
  input  logic       alarm_clr_i,
  output logic [6:0] hrhighbcd,
  output logic [6:0] hrlowbcd,
  output logic [6:0] minhighbcd,
  output logic [6:0] minlowbcd,
  output logic [6:0] sechighbcd,
  output logic [6:0] seclowbcd,
  output logic       pm_o,
  output logic       sec_tick_o,
  output logic       alarm_o,
  output logic       load_err_o
);
  localparam logic [23:0] PRESC_LAST = 24'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  TMO_LAST   = 8'(ALARM_TIMEOUT - 1);
  localparam clock_time_t RESET_TIME =
    {(MODE_24H ? 4'd0 : 4'd1), (MODE_24H ? 4'd0 : 4'd2), 16'd0, 1'b0};

  logic [23:0] presc_q, presc_d;
  clock_time_t time_q, time_d, time_adv, load_value;
  clock_time_t alarm_q, alarm_d;
  logic        armed_q, armed_d, ring_q, ring_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        load_prev_q, load_prev_d, err_q, err_d;
  logic        digits_ok, load_act, tick, fire;

  function automatic logic digits_valid(input bcd_t hh, input bcd_t hl,
                                        input bcd_t mh, input bcd_t ml);
    logic [7:0] hours;
    logic       hours_ok;
    hours = bcd2_to_bin(hh, hl);
    if (MODE_24H) hours_ok = (hours <= HOUR24_MAX);
    else          hours_ok = (hours >= HOUR12_MIN) && (hours <= HOUR12_MAX);
    return hours_ok && (hl <= DIGIT_MAX) && (mh <= TENS_MAX) && (ml <= DIGIT_MAX);
  endfunction

  // Returns {hh_hi, hh_lo, pm}; in 12-hour mode 11->12 flips am/pm, 12->01 does not.
  function automatic logic [8:0] next_hour(input bcd_t hi, input bcd_t lo, input logic pm);
    logic [7:0] hours;
    hours = bcd2_to_bin(hi, lo);
    if (MODE_24H) begin
      if (hours == HOUR24_MAX) return {8'h00, 1'b0};
    end else begin
      if (hours == HOUR12_MAX - 8'd1) return {4'd1, 4'd2, ~pm};
      if (hours == HOUR12_MAX)        return {4'd0, 4'd1, pm};
    end
    if (lo == DIGIT_MAX) return {hi + 4'd1, 4'd0, pm};
    return {hi, lo + 4'd1, pm};
  endfunction

  function automatic clock_time_t advance(input clock_time_t t);
    clock_time_t n;
    n = t;
    if (t.ss_lo != DIGIT_MAX) n.ss_lo = t.ss_lo + 4'd1;
    else begin
      n.ss_lo = 4'd0;
      if (t.ss_hi != TENS_MAX) n.ss_hi = t.ss_hi + 4'd1;
      else begin
        n.ss_hi = 4'd0;
        if (t.mm_lo != DIGIT_MAX) n.mm_lo = t.mm_lo + 4'd1;
        else begin
          n.mm_lo = 4'd0;
          if (t.mm_hi != TENS_MAX) n.mm_hi = t.mm_hi + 4'd1;
          else begin
            n.mm_hi = 4'd0;
            {n.hh_hi, n.hh_lo, n.pm} = next_hour(t.hh_hi, t.hh_lo, t.pm);
          end
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    digits_ok        = digits_valid(Lhourhigh, Lhourlow, Lminhigh, Lminlow);
    load_act         = loadOrNah && digits_ok;
    load_value       = '0;
    load_value.hh_hi = Lhourhigh;
    load_value.hh_lo = Lhourlow;
    load_value.mm_hi = Lminhigh;
    load_value.mm_lo = Lminlow;
    load_value.pm    = Lpm & ~MODE_24H;
    // A held load parks the prescaler, so no second boundary can occur under it.
    tick     = (presc_q == PRESC_LAST) && !load_act;
    time_adv = advance(time_q);
    fire     = armed_q && tick && (time_adv == alarm_q);

    presc_d = (load_act || presc_q == PRESC_LAST) ? 24'd0 : presc_q + 24'd1;
    time_d  = time_q;
    if (load_act)  time_d = load_value;
    else if (tick) time_d = time_adv;

    alarm_d = alarm_q;
    armed_d = armed_q;
    if (alarm_clr_i) armed_d = 1'b0;
    if (alarm_set_i && digits_ok) begin
      alarm_d = load_value;
      armed_d = 1'b1;
    end

    ring_d = ring_q;
    tmo_d  = tmo_q;
    if (alarm_clr_i) begin
      ring_d = 1'b0;
      tmo_d  = 8'd0;
    end else if (fire) begin
      ring_d = 1'b1;
      tmo_d  = 8'd0;
    end else if (ring_q && tick) begin
      if (tmo_q == TMO_LAST) begin
        ring_d = 1'b0;
        tmo_d  = 8'd0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end

    load_prev_d = loadOrNah;
    err_d = (loadOrNah && !load_prev_q && !digits_ok) || (alarm_set_i && !digits_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q     <= 24'd0;
      time_q      <= RESET_TIME;
      armed_q     <= 1'b0;
      ring_q      <= 1'b0;
      tmo_q       <= 8'd0;
      load_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      armed_q     <= armed_d;
      ring_q      <= ring_d;
      tmo_q       <= tmo_d;
      load_prev_q <= load_prev_d;
      err_q       <= err_d;
    end
  end

  // The stored alarm time is only meaningful while armed, so it needs no reset.
  always_ff @(posedge clk_i) begin
    alarm_q <= alarm_d;
  end

  logic [6:0] hh_hi_seg;

  bcd_to_7seg u_seg_hh_hi (.digit_i(time_q.hh_hi), .seg_o(hh_hi_seg));
  bcd_to_7seg u_seg_hh_lo (.digit_i(time_q.hh_lo), .seg_o(hrlowbcd));
  bcd_to_7seg u_seg_mm_hi (.digit_i(time_q.mm_hi), .seg_o(minhighbcd));
  bcd_to_7seg u_seg_mm_lo (.digit_i(time_q.mm_lo), .seg_o(minlowbcd));
  bcd_to_7seg u_seg_ss_hi (.digit_i(time_q.ss_hi), .seg_o(sechighbcd));
  bcd_to_7seg u_seg_ss_lo (.digit_i(time_q.ss_lo), .seg_o(seclowbcd));

  assign hrhighbcd  = (!MODE_24H && time_q.hh_hi == 4'd0) ? SEG_BLANK : hh_hi_seg;
  assign pm_o       = time_q.pm & ~MODE_24H;
  assign sec_tick_o = tick;
  assign alarm_o    = ring_q;
  assign load_err_o = err_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: a 12-hour and a 24-hour instance share stimulus and
// are checked every cycle against a seconds-of-day model plus literal expectations.
module tb_alarm_clock_core;
  localparam int T   = 2;
  localparam int TMO = 60;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] lhh = 4'd0, lhl = 4'd0, lmh = 4'd0, lml = 4'd0;
  logic       lpm = 1'b0, load = 1'b0, aset = 1'b0, aclr = 1'b0;
  logic [6:0] seg12 [6];
  logic [6:0] seg24 [6];
  logic       pm_a [2], tick_a [2], al_a [2], err_a [2];

  always #5 clk = ~clk;

  alarm_clock_core #(.TICKS_PER_SEC(T), .MODE_24H(1'b0), .ALARM_TIMEOUT(TMO)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .Lhourhigh(lhh), .Lhourlow(lhl), .Lminhigh(lmh),
    .Lminlow(lml), .Lpm(lpm), .loadOrNah(load), .alarm_set_i(aset), .alarm_clr_i(aclr),
    .hrhighbcd(seg12[0]), .hrlowbcd(seg12[1]), .minhighbcd(seg12[2]),
    .minlowbcd(seg12[3]), .sechighbcd(seg12[4]), .seclowbcd(seg12[5]),
    .pm_o(pm_a[0]), .sec_tick_o(tick_a[0]), .alarm_o(al_a[0]), .load_err_o(err_a[0]));

  alarm_clock_core #(.TICKS_PER_SEC(T), .MODE_24H(1'b1), .ALARM_TIMEOUT(TMO)) u_dut24 (
    .clk_i(clk), .rst_i(rst), .Lhourhigh(lhh), .Lhourlow(lhl), .Lminhigh(lmh),
    .Lminlow(lml), .Lpm(lpm), .loadOrNah(load), .alarm_set_i(aset), .alarm_clr_i(aclr),
    .hrhighbcd(seg24[0]), .hrlowbcd(seg24[1]), .minhighbcd(seg24[2]),
    .minlowbcd(seg24[3]), .sechighbcd(seg24[4]), .seclowbcd(seg24[5]),
    .pm_o(pm_a[1]), .sec_tick_o(tick_a[1]), .alarm_o(al_a[1]), .load_err_o(err_a[1]));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int m, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0s actual=%h required=%h at t=%0t", name, (m == 0) ? "12" : "24",
               act, exp, $time);
    end
  endtask

  // Model state: time of day as seconds since midnight, per instance (0=12h, 1=24h).
  int presc [2], sod [2], al_sod [2], rcnt [2];
  bit armed [2], ring [2], errm [2], lprev [2];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic bit valid_digits(input int m, input int hh, input int hl, input int mh, input int ml);
    int h;
    h = hh * 10 + hl;
    if (hl > 9 || mh > 5 || ml > 9) return 1'b0;
    return (m == 1) ? (h <= 23) : (h >= 1 && h <= 12);
  endfunction

  function automatic int to_sod(input int m, input int hh, input int hl, input int mh,
                                input int ml, input bit pm);
    int h;
    h = hh * 10 + hl;
    if (m == 0) h = (h % 12) + (pm ? 12 : 0);
    return h * 3600 + (mh * 10 + ml) * 60;
  endfunction

  function automatic bit cur_valid(input int m);
    return valid_digits(m, int'(lhh), int'(lhl), int'(lmh), int'(lml));
  endfunction

  always @(posedge clk) begin : model
    bit ok, la, tk, fi;
    int ld;
    for (int m = 0; m < 2; m++) begin
      ok = cur_valid(m);
      la = load && ok;
      tk = (presc[m] == T - 1) && !la;
      fi = armed[m] && tk && (((sod[m] + 1) % DAY) == al_sod[m]);
      ld = to_sod(m, int'(lhh), int'(lhl), int'(lmh), int'(lml), lpm);
      if (rst) begin
        presc[m] <= 0; sod[m] <= 0; armed[m] <= 1'b0; ring[m] <= 1'b0;
        rcnt[m] <= 0; errm[m] <= 1'b0; lprev[m] <= 1'b0;
      end else begin
        errm[m]  <= (load && !lprev[m] && !ok) || (aset && !ok);
        lprev[m] <= load;
        if (aclr) begin
          ring[m] <= 1'b0; rcnt[m] <= 0;
        end else if (fi) begin
          ring[m] <= 1'b1; rcnt[m] <= 0;
        end else if (ring[m] && tk) begin
          if (rcnt[m] + 1 == TMO) begin ring[m] <= 1'b0; rcnt[m] <= 0; end
          else rcnt[m] <= rcnt[m] + 1;
        end
        if (aclr) armed[m] <= 1'b0;
        if (aset && ok) begin armed[m] <= 1'b1; al_sod[m] <= ld; end
        if (la) begin
          sod[m] <= ld; presc[m] <= 0;
        end else begin
          if (tk) sod[m] <= (sod[m] + 1) % DAY;
          presc[m] <= (presc[m] == T - 1) ? 0 : presc[m] + 1;
        end
      end
    end
  end

  task automatic check_dut(input int m, input logic [6:0] s [6], input logic pm,
                           input logic tk, input logic al, input logic er);
    int h24, dh, mn, sc;
    logic [6:0] e [6];
    h24 = sod[m] / 3600;
    mn  = (sod[m] / 60) % 60;
    sc  = sod[m] % 60;
    dh  = (m == 1) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    e[0] = (m == 0 && dh / 10 == 0) ? 7'h00 : seg_of(dh / 10);
    e[1] = seg_of(dh % 10);
    e[2] = seg_of(mn / 10);
    e[3] = seg_of(mn % 10);
    e[4] = seg_of(sc / 10);
    e[5] = seg_of(sc % 10);
    for (int i = 0; i < 6; i++) chk($sformatf("seg%0d", i), m, {1'b0, s[i]}, {1'b0, e[i]});
    chk("pm", m, 8'(pm), 8'(m == 0 && h24 >= 12));
    chk("sec_tick", m, 8'(tk), 8'(presc[m] == T - 1 && !(load && cur_valid(m))));
    chk("alarm", m, 8'(al), 8'(ring[m]));
    chk("load_err", m, 8'(er), 8'(errm[m]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, seg12, pm_a[0], tick_a[0], al_a[0], err_a[0]);
      check_dut(1, seg24, pm_a[1], tick_a[1], al_a[1], err_a[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int hh, input int hl, input int mh, input int ml, input bit pm);
    lhh = 4'(hh); lhl = 4'(hl); lmh = 4'(mh); lml = 4'(ml); lpm = pm;
  endtask

  task automatic do_load(input int hh, input int hl, input int mh, input int ml, input bit pm);
    drive(hh, hl, mh, ml, pm);
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_set(input int hh, input int hl, input int mh, input int ml, input bit pm);
    drive(hh, hl, mh, ml, pm);
    aset = 1'b1;
    step(1);
    aset = 1'b0;
  endtask

  task automatic lit_time(input string tag, input int m, input logic [6:0] s [6],
                          input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                          input logic [6:0] e3);
    chk({tag, "_hh_hi"}, m, {1'b0, s[0]}, {1'b0, e0});
    chk({tag, "_hh_lo"}, m, {1'b0, s[1]}, {1'b0, e1});
    chk({tag, "_mm_hi"}, m, {1'b0, s[2]}, {1'b0, e2});
    chk({tag, "_mm_lo"}, m, {1'b0, s[3]}, {1'b0, e3});
    chk({tag, "_ss_hi"}, m, {1'b0, s[4]}, 8'h3F);
    chk({tag, "_ss_lo"}, m, {1'b0, s[5]}, 8'h3F);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    lit_time("reset", 0, seg12, 7'h06, 7'h5B, 7'h3F, 7'h3F);
    lit_time("reset", 1, seg24, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    chk("reset_pm", 0, 8'(pm_a[0]), 8'h00);
    chk("reset_tick0", 0, 8'(tick_a[0]), 8'h00);
    step(1);
    chk("reset_tick1", 0, 8'(tick_a[0]), 8'h01);

    do_load(1, 1, 5, 9, 1'b1);
    step(120);
    lit_time("noon_to_midnight", 0, seg12, 7'h06, 7'h5B, 7'h3F, 7'h3F);
    chk("midnight_pm", 0, 8'(pm_a[0]), 8'h00);
    lit_time("noon24", 1, seg24, 7'h06, 7'h5B, 7'h3F, 7'h3F);

    do_load(1, 2, 5, 9, 1'b0);
    step(120);
    lit_time("one_am", 0, seg12, 7'h00, 7'h06, 7'h3F, 7'h3F);
    chk("one_am_pm", 0, 8'(pm_a[0]), 8'h00);
    lit_time("thirteen", 1, seg24, 7'h06, 7'h4F, 7'h3F, 7'h3F);

    do_load(2, 3, 5, 9, 1'b0);
    chk("err_2359_12h", 0, 8'(err_a[0]), 8'h01);
    chk("err_2359_24h", 1, 8'(err_a[1]), 8'h00);
    step(120);
    lit_time("midnight24", 1, seg24, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    chk("midnight24_pm", 1, 8'(pm_a[1]), 8'h00);

    drive(1, 3, 7, 5, 1'b0);
    load = 1'b1;
    step(1);
    chk("err_1375_first", 0, 8'(err_a[0]), 8'h01);
    chk("err_1375_first", 1, 8'(err_a[1]), 8'h01);
    step(1);
    chk("err_1375_held", 0, 8'(err_a[0]), 8'h00);
    step(1);
    drive(1, 0, 3, 0, 1'b0);
    step(5);
    lit_time("held_load", 0, seg12, 7'h06, 7'h3F, 7'h4F, 7'h3F);
    chk("held_no_tick", 0, 8'(tick_a[0]), 8'h00);
    load = 1'b0;
    #1;
    chk("release_tick0", 0, 8'(tick_a[0]), 8'h00);
    step(1);
    chk("release_tick1", 0, 8'(tick_a[0]), 8'h01);

    do_set(0, 7, 0, 0, 1'b0);
    do_load(0, 6, 5, 9, 1'b0);
    step(119);
    chk("alarm_before", 0, 8'(al_a[0]), 8'h00);
    step(1);
    chk("alarm_fire", 0, 8'(al_a[0]), 8'h01);
    chk("alarm_fire", 1, 8'(al_a[1]), 8'h01);
    chk("fire_hh_lo", 0, {1'b0, seg12[1]}, 8'h07);
    aclr = 1'b1;
    step(1);
    aclr = 1'b0;
    chk("alarm_cleared", 0, 8'(al_a[0]), 8'h00);

    do_set(0, 7, 0, 0, 1'b0);
    do_load(0, 6, 5, 9, 1'b0);
    step(120);
    chk("alarm_fire2", 0, 8'(al_a[0]), 8'h01);
    step(119);
    chk("alarm_ringing", 0, 8'(al_a[0]), 8'h01);
    step(1);
    chk("alarm_timeout", 0, 8'(al_a[0]), 8'h00);
    chk("alarm_timeout", 1, 8'(al_a[1]), 8'h00);

    do_load(0, 7, 0, 0, 1'b0);
    chk("load_on_alarm", 0, 8'(al_a[0]), 8'h00);

    do_load(0, 6, 5, 9, 1'b0);
    step(120);
    chk("armed_after_timeout", 0, 8'(al_a[0]), 8'h01);
    rst = 1'b1;
    step(1);
    chk("reset_alarm", 0, 8'(al_a[0]), 8'h00);
    lit_time("reset_ringing", 0, seg12, 7'h06, 7'h5B, 7'h3F, 7'h3F);
    rst = 1'b0;
    do_load(0, 6, 5, 9, 1'b0);
    step(121);
    chk("disarmed_by_reset", 0, 8'(al_a[0]), 8'h00);

    do_set(0, 7, 0, 0, 1'b0);
    do_load(0, 6, 5, 9, 1'b0);
    step(119);
    aclr = 1'b1;
    step(1);
    aclr = 1'b0;
    chk("clear_beats_fire", 0, 8'(al_a[0]), 8'h00);
    chk("clear_beats_fire", 1, 8'(al_a[1]), 8'h00);

    do_set(2, 5, 0, 0, 1'b0);
    chk("bad_alarm_set", 0, 8'(err_a[0]), 8'h01);
    chk("bad_alarm_set", 1, 8'(err_a[1]), 8'h01);
    drive(0, 8, 1, 5, 1'b1);
    aset = 1'b1;
    load = 1'b1;
    step(1);
    aset = 1'b0;
    load = 1'b0;
    lit_time("set_and_load", 0, seg12, 7'h00, 7'h7F, 7'h06, 7'h6D);
    chk("set_and_load_pm", 0, 8'(pm_a[0]), 8'h01);
    step(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
